n64adv_vpll_manager: RTL



---
 rtl/n64adv_vpll_manager.sv | 138 +++++++++++++
 1 files changed

// File: rtl/n64adv_vpll_manager.sv
`default_nettype none
// ============================================================================
// Module  : n64adv_vpll_manager
// Brief   : Brings the 75 MHz video PLL up (test, lock qualify, engage), then
//           switches VCLK_select[1] to it; falls back cleanly on lock loss or
//           request removal. Optional macro: VPLL_AUTO_RETRY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module n64adv_vpll_manager #(
  parameter int LOCK_TIMEOUT = 4000,
  parameter int STABLE_CNT   = 256,
  parameter int SWITCH_DELAY = 64,
  parameter int RETRY_DELAY  = 40000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       SYS_CLK,
  input  logic       SRST,
  input  logic [1:0] VCLK_SEL_REQ,
  input  logic       VCLK_PLL_LOCKED,
  output logic [1:0] MANAGE_VPLL,
  output logic [1:0] VCLK_select,
  output logic [1:0] VPLL_STATUS,
  output logic [1:0] RETRY_CNT
);

  localparam logic [19:0] C_TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] C_STABLE_LAST  = 20'(STABLE_CNT - 1);
  localparam logic [19:0] C_SWITCH_LAST  = 20'(SWITCH_DELAY - 1);
`ifdef VPLL_AUTO_RETRY_EN
  localparam logic [19:0] C_RETRY_LAST   = 20'(RETRY_DELAY - 1);
  localparam logic [1:0]  C_MAX_RETRIES  = 2'(MAX_RETRIES);
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = ^{20'(RETRY_DELAY), 2'(MAX_RETRIES)};
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TEST    = 3'd1,
    S_STABLE  = 3'd2,
    S_ENGAGE  = 3'd3,
    S_RUN     = 3'd4,
    S_RELEASE = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q;
  logic [1:0]  req_q;
  logic        lock_meta_q, lock_s_q;
  logic [1:0]  retry_q, retry_d;
  logic [1:0]  manage_q, vclk_sel_q, status_q;

  // Priority inside each state: request drop, then lock loss, then counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_q[1]) state_d = S_TEST;
      S_TEST: begin
        if (!req_q[1])                     state_d = S_IDLE;
        else if (lock_s_q)                 state_d = S_STABLE;
        else if (cnt_q == C_TIMEOUT_LAST)  state_d = S_FAIL;
      end
      S_STABLE: begin
        if (!req_q[1])                     state_d = S_IDLE;
        else if (!lock_s_q)                state_d = S_TEST;
        else if (cnt_q == C_STABLE_LAST)   state_d = S_ENGAGE;
      end
      S_ENGAGE: begin
        if (!req_q[1])                     state_d = S_RELEASE;
        else if (!lock_s_q)                state_d = S_FAIL;
        else if (cnt_q == C_SWITCH_LAST)   state_d = S_RUN;
      end
      S_RUN: begin
        if (!req_q[1])                     state_d = S_RELEASE;
        else if (!lock_s_q)                state_d = S_FAIL;
      end
      S_RELEASE: if (cnt_q == C_SWITCH_LAST) state_d = S_IDLE;
      S_FAIL: begin
        if (!req_q[1])                     state_d = S_IDLE;
`ifdef VPLL_AUTO_RETRY_EN
        else if (cnt_q == C_RETRY_LAST && retry_q < C_MAX_RETRIES)
                                           state_d = S_TEST;
`endif
      end
      default:                             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    retry_d = retry_q;
    if (state_d == S_IDLE || state_d == S_RUN)
      retry_d = 2'd0;
`ifdef VPLL_AUTO_RETRY_EN
    else if (state_q == S_FAIL && state_d == S_TEST)
      retry_d = retry_q + 2'd1;
`endif
  end

  // Outputs are decoded from the state being entered so they change on the
  // same edge as the state register.
  always_ff @(posedge SYS_CLK) begin
    if (SRST) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      req_q       <= 2'b00;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      manage_q    <= 2'b00;
      vclk_sel_q  <= 2'b00;
      status_q    <= 2'b00;
    end else begin
      lock_meta_q <= VCLK_PLL_LOCKED;
      lock_s_q    <= lock_meta_q;
      req_q       <= VCLK_SEL_REQ;
      state_q     <= state_d;
      cnt_q       <= (state_d != state_q) ? 20'd0 : cnt_q + 20'd1;
      retry_q     <= retry_d;
      vclk_sel_q  <= {state_d == S_RUN, req_q[0]};
      case (state_d)
        S_TEST, S_STABLE: begin manage_q <= 2'b01; status_q <= 2'b01; end
        S_ENGAGE:         begin manage_q <= 2'b10; status_q <= 2'b01; end
        S_RUN:            begin manage_q <= 2'b10; status_q <= 2'b10; end
        S_RELEASE:        begin manage_q <= 2'b10; status_q <= 2'b01; end
        S_FAIL:           begin manage_q <= 2'b00; status_q <= 2'b11; end
        default:          begin manage_q <= 2'b00; status_q <= 2'b00; end
      endcase
    end
  end

  assign MANAGE_VPLL = manage_q;
  assign VCLK_select = vclk_sel_q;
  assign VPLL_STATUS = status_q;
  assign RETRY_CNT   = retry_q;

endmodule
`default_nettype wire
